// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode constants and instruction length decode shared by fetch and decode.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_REST  = 2'd2,
    S_RESP  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [3:0] len;
    logic       invalid;
  } instr_len_t;

  // Unknown icodes still consume one byte so fetch can report them.
  function automatic instr_len_t instr_len(input logic [3:0] icode);
    instr_len_t r;
    r.invalid = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RET:                r.len = 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    r.len = 4'd2;
      I_JXX, I_CALL:                       r.len = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        r.len = 4'd10;
      default: begin
        r.len     = 4'd1;
        r.invalid = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// rtl/imem_fetch_responder_if.sv - Load port and fetch req/rsp bundle between fetch and instruction memory.
interface imem_fetch_responder_if #(
  parameter int ADDR_W = 10
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              req;
  logic [63:0]       req_pc;
  logic              busy;
  logic              rsp_valid;
  logic [79:0]       rsp_bytes;
  logic [3:0]        rsp_len;
  logic              rsp_invalid;
  logic              imem_error;

  modport master (
    output load_en, load_addr, load_data, req, req_pc,
    input  busy, rsp_valid, rsp_bytes, rsp_len, rsp_invalid, imem_error
  );

  modport slave (
    input  load_en, load_addr, load_data, req, req_pc,
    output busy, rsp_valid, rsp_bytes, rsp_len, rsp_invalid, imem_error
  );
endinterface

// File: rtl/imem_byte_ram.sv
// rtl/imem_byte_ram.sv - Byte-wide program store with synchronous write and combinational read.
module imem_byte_ram #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEM_BYTES);

  logic [7:0] mem [MEM_BYTES];

  // Program contents survive reset, so the array has no reset term.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < MEM_LIM)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - Fetch responder: decodes icode, gathers instruction bytes one per cycle, returns 80-bit window.
module imem_fetch_responder
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imem_fetch_responder_if.slave  bus
);

  localparam logic [63:0] MEM_LIM = 64'(MEM_BYTES);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [79:0]  bytes_q, bytes_d;
  logic [3:0]   len_q, len_d;
  logic         inv_q, inv_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;

  logic [63:0]  rd_addr;
  logic [7:0]   rd_data;
  instr_len_t   dec;

  imem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (bus.load_en),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (rd_addr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  assign rd_addr = (state_q == S_REST) ? (pc_q + 64'(cnt_q)) : pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    len_d   = len_q;
    inv_d   = inv_q;
    err_d   = err_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    dec     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          busy_d  = 1'b1;
          pc_d    = bus.req_pc;
          cnt_d   = 4'd0;
          bytes_d = '0;
          len_d   = 4'd0;
          inv_d   = 1'b0;
          err_d   = 1'b0;
          if (bus.req_pc >= MEM_LIM) begin
            err_d   = 1'b1;
            valid_d = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        dec           = instr_len(rd_data[7:4]);
        bytes_d[7:0]  = rd_data;
        len_d         = dec.len;
        inv_d         = dec.invalid;
        if (dec.len == 4'd1) begin
          valid_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = 4'd1;
          state_d = S_REST;
        end
      end
      S_REST: begin
        // Running off the end of the store cuts the instruction short.
        if (rd_addr >= MEM_LIM) begin
          err_d   = 1'b1;
          valid_d = 1'b1;
          state_d = S_RESP;
        end else begin
          bytes_d[{cnt_q, 3'b000} +: 8] = rd_data;
          if (cnt_q == len_q - 4'd1) begin
            valid_d = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      bytes_q <= '0;
      len_q   <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      bytes_q <= bytes_d;
      len_q   <= len_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.rsp_valid   = valid_q;
  assign bus.rsp_bytes   = bytes_q;
  assign bus.rsp_len     = len_q;
  assign bus.rsp_invalid = inv_q;
  assign bus.imem_error  = err_q;

endmodule
